// File: rtl/adc0808_scan_ctrl.sv
// Conversion sequencer for an external ADC0808/0809: scans channels 0..3 once per init
// request and leaves the four results plus done/timeout status for the J1 ADC peripheral.
module adc0808_scan_ctrl #(
  parameter int SETUP_CYC   = 2,
  parameter int PULSE_CYC   = 4,
  parameter int EOC_LOW_TO  = 64,
  parameter int EOC_HIGH_TO = 2048,
  parameter int READ_CYC    = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       init_i,
  input  logic       eoc_i,
  input  logic [7:0] datain_i,
  output logic [2:0] add_o,
  output logic       ale_o,
  output logic       start_o,
  output logic       oe_o,
  output logic [7:0] r1_o,
  output logic [7:0] r2_o,
  output logic [7:0] r3_o,
  output logic [7:0] r4_o,
  output logic       done_o,
  output logic       timeout_err_o
);

  localparam int CW = $clog2(EOC_HIGH_TO) + 1;

  localparam logic [CW-1:0] SetupLast  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PulseLast  = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] EocLowLast = CW'(EOC_LOW_TO - 1);
  localparam logic [CW-1:0] EocHiLast  = CW'(EOC_HIGH_TO - 1);
  localparam logic [CW-1:0] ReadLast   = CW'(READ_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    WAIT_LO,
    WAIT_HI,
    READ,
    NEXT
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      ch_q;
  logic [1:0]      eocSync_q;
  logic [2:0]      add_q;
  logic            strobe_q;
  logic            oe_q;
  logic            done_q;
  logic            timeoutErr_q;
  logic [7:0]      res_q [4];
  logic            eocSynced;

  assign eocSynced = eocSync_q[1];

  // EOC is asynchronous to clk; idle level is high, so the synchroniser resets to ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      eocSync_q <= 2'b11;
    end else begin
      eocSync_q <= {eocSync_q[0], eoc_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ch_q         <= 2'd0;
      add_q        <= 3'd0;
      strobe_q     <= 1'b0;
      oe_q         <= 1'b0;
      done_q       <= 1'b0;
      timeoutErr_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        res_q[i] <= 8'h00;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (init_i) begin
            ch_q         <= 2'd0;
            add_q        <= 3'd0;
            done_q       <= 1'b0;
            timeoutErr_q <= 1'b0;
            cnt_q        <= '0;
            state_q      <= SETUP;
          end
        end

        SETUP: begin
          if (cnt_q == SetupLast) begin
            cnt_q    <= '0;
            strobe_q <= 1'b1;
            state_q  <= PULSE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        PULSE: begin
          if (cnt_q == PulseLast) begin
            cnt_q    <= '0;
            strobe_q <= 1'b0;
            state_q  <= WAIT_LO;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        // A missing EOC edge writes the 8'hFF marker instead of reading the bus.
        WAIT_LO: begin
          if (!eocSynced) begin
            cnt_q   <= '0;
            state_q <= WAIT_HI;
          end else if (cnt_q == EocLowLast) begin
            cnt_q        <= '0;
            res_q[ch_q]  <= 8'hFF;
            timeoutErr_q <= 1'b1;
            state_q      <= NEXT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        WAIT_HI: begin
          if (eocSynced) begin
            cnt_q   <= '0;
            oe_q    <= 1'b1;
            state_q <= READ;
          end else if (cnt_q == EocHiLast) begin
            cnt_q        <= '0;
            res_q[ch_q]  <= 8'hFF;
            timeoutErr_q <= 1'b1;
            state_q      <= NEXT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        READ: begin
          if (cnt_q == ReadLast) begin
            cnt_q       <= '0;
            res_q[ch_q] <= datain_i;
            oe_q        <= 1'b0;
            state_q     <= NEXT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        NEXT: begin
          cnt_q <= '0;
          if (ch_q == 2'd3) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            ch_q    <= ch_q + 2'd1;
            add_q   <= {1'b0, ch_q + 2'd1};
            state_q <= SETUP;
          end
        end

        default: begin
          state_q  <= IDLE;
          strobe_q <= 1'b0;
          oe_q     <= 1'b0;
          cnt_q    <= '0;
        end
      endcase
    end
  end

  assign add_o         = add_q;
  assign ale_o         = strobe_q;
  assign start_o       = strobe_q;
  assign oe_o          = oe_q;
  assign r1_o          = res_q[0];
  assign r2_o          = res_q[1];
  assign r3_o          = res_q[2];
  assign r4_o          = res_q[3];
  assign done_o        = done_q;
  assign timeout_err_o = timeoutErr_q;

endmodule

// File: tb/tb_adc0808_scan_ctrl.sv
// Self-checking bench for adc0808_scan_ctrl: a behavioural ADC0808 model plus a result
// scoreboard filled when each scan is requested and drained when done rises.
module tb_adc0808_scan_ctrl;

  typedef struct packed {
    logic [7:0] r1;
    logic [7:0] r2;
    logic [7:0] r3;
    logic [7:0] r4;
    logic       terr;
  } expT;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       init = 1'b0;
  logic       eoc = 1'b1;
  logic [7:0] datain;
  logic [2:0] add;
  logic       ale, start, oe, done, terr;
  logic [7:0] r1, r2, r3, r4;

  int checks = 0;
  int errors = 0;
  expT sbQ[$];

  // ADC model configuration and state
  logic [7:0] dataTab [4];
  int         eocLo = 8;
  int         eocHi = 100;
  int         stuckCh = -1;
  logic [1:0] latchCh = 2'd0;
  int         phase = 0;
  int         mcnt = 0;
  logic       prevStart = 1'b0;

  adc0808_scan_ctrl dut (
    .clk_i(clk), .rst_ni(rstN), .init_i(init), .eoc_i(eoc), .datain_i(datain),
    .add_o(add), .ale_o(ale), .start_o(start), .oe_o(oe),
    .r1_o(r1), .r2_o(r2), .r3_o(r3), .r4_o(r4),
    .done_o(done), .timeout_err_o(terr)
  );

  initial forever #5 clk = ~clk;

  assign datain = oe ? dataTab[latchCh] : 8'h00;

  // START rise latches the channel; EOC falls eocLo cycles after START falls, rises eocHi later.
  always @(negedge clk) begin
    if (!rstN) begin
      phase = 0;
      eoc   = 1'b1;
    end else if (start && !prevStart) begin
      latchCh = add[1:0];
      eoc     = 1'b1;
      phase   = (stuckCh == int'(add)) ? 0 : 1;
    end else begin
      case (phase)
        1: if (!start) begin mcnt = 0; phase = 2; end
        2: begin
          mcnt++;
          if (mcnt >= eocLo) begin eoc = 1'b0; mcnt = 0; phase = 3; end
        end
        3: begin
          mcnt++;
          if (mcnt >= eocHi) begin eoc = 1'b1; phase = 0; end
        end
        default: ;
      endcase
    end
    prevStart = start;
  end

  task automatic startScan();
    @(negedge clk) init = 1'b1;
    @(negedge clk) init = 1'b0;
  endtask

  task automatic waitDone(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    init = 1'b0;
    #3;
    checks++;
    if ({add, ale, start, oe} !== 6'd0)
      $display("[TB] FAIL reset_strobes: got %h expected 00", {add, ale, start, oe});
    checks++;
    if ({r1, r2, r3, r4} !== 32'd0)
      $display("[TB] FAIL reset_results: got %h expected 00000000", {r1, r2, r3, r4});
    checks++;
    if ({done, terr} !== 2'b00)
      $display("[TB] FAIL reset_status: got %b expected 00", {done, terr});
    if ({add, ale, start, oe} !== 6'd0) errors++;
    if ({r1, r2, r3, r4} !== 32'd0) errors++;
    if ({done, terr} !== 2'b00) errors++;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_scan_timing();
    int aleRise = 0, aleLen = 0, oeLen = 0, oeCount = 0, addStable = 0;
    int badSeq = 0, badSetup = 0, badAleLen = 0, badAleStart = 0, badOe = 0;
    logic prevAle = 1'b0, prevOe = 1'b0;
    logic [2:0] prevAdd = 3'd7;
    bit finished = 1'b0;
    expT e;
    dataTab = '{8'h11, 8'h22, 8'h33, 8'h44};
    stuckCh = -1;
    sbQ.push_back('{8'h11, 8'h22, 8'h33, 8'h44, 1'b0});
    startScan();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (done === 1'b1) begin finished = 1'b1; break; end
      if (ale !== start) badAleStart++;
      addStable = (add === prevAdd) ? addStable + 1 : 1;
      if (ale && !prevAle) begin
        if (add !== aleRise[2:0]) badSeq++;
        if (addStable < 3) badSetup++;
        aleRise++;
        aleLen = 0;
      end
      if (ale) aleLen++;
      if (!ale && prevAle && aleLen != 4) badAleLen++;
      if (oe) oeLen++;
      if (!oe && prevOe) begin
        if (oeLen != 3) badOe++;
        oeCount++;
        oeLen = 0;
      end
      prevAle = ale;
      prevOe  = oe;
      prevAdd = add;
    end
    checks++;
    if (!finished) begin errors++; $display("[TB] FAIL scan_done: got 0 expected 1"); end
    checks++;
    if (aleRise != 4) begin errors++; $display("[TB] FAIL ale_pulses: got %0d expected 4", aleRise); end
    checks++;
    if (badSeq != 0) begin errors++; $display("[TB] FAIL add_sequence: got %0d bad expected 0", badSeq); end
    checks++;
    if (badSetup != 0) begin errors++; $display("[TB] FAIL add_setup: got %0d short expected 0", badSetup); end
    checks++;
    if (badAleLen != 0) begin errors++; $display("[TB] FAIL ale_width: got %0d bad expected 0", badAleLen); end
    checks++;
    if (badAleStart != 0) begin errors++; $display("[TB] FAIL ale_eq_start: got %0d bad expected 0", badAleStart); end
    checks++;
    if (oeCount != 4 || badOe != 0) begin
      errors++;
      $display("[TB] FAIL oe_pulses: got %0d pulses %0d bad expected 4 pulses 0 bad", oeCount, badOe);
    end
    e = sbQ.pop_front();
    checks++;
    if ({r1, r2, r3, r4, terr} !== e) begin
      errors++;
      $display("[TB] FAIL scan_results: got %h expected %h", {r1, r2, r3, r4, terr}, e);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    expT e;
    dataTab = '{8'h31, 8'h32, 8'h33, 8'h34};
    stuckCh = 2;
    sbQ.push_back('{8'h31, 8'h32, 8'hFF, 8'h34, 1'b1});
    startScan();
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL done_cleared: got %b expected 0", done); end
    waitDone(3000, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL timeout_done: got 0 expected 1"); end
    e = sbQ.pop_front();
    checks++;
    if ({r1, r2, r3, r4, terr} !== e) begin
      errors++;
      $display("[TB] FAIL timeout_results: got %h expected %h", {r1, r2, r3, r4, terr}, e);
    end
    stuckCh = -1;
  endtask

  task automatic test_continuous();
    bit ok;
    expT e;
    dataTab = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    sbQ.push_back('{8'hA0, 8'hA1, 8'hA2, 8'hA3, 1'b0});
    @(negedge clk) init = 1'b1;
    @(negedge clk);
    waitDone(3000, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL cont_done1: got 0 expected 1"); end
    e = sbQ.pop_front();
    checks++;
    if ({r1, r2, r3, r4, terr} !== e) begin
      errors++;
      $display("[TB] FAIL cont_results1: got %h expected %h", {r1, r2, r3, r4, terr}, e);
    end
    dataTab = '{8'hA4, 8'hA5, 8'hA6, 8'hA7};
    sbQ.push_back('{8'hA4, 8'hA5, 8'hA6, 8'hA7, 1'b0});
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL done_one_cycle: got %b expected 0", done); end
    waitDone(3000, ok);
    init = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL cont_done2: got 0 expected 1"); end
    e = sbQ.pop_front();
    checks++;
    if ({r1, r2, r3, r4, terr} !== e) begin
      errors++;
      $display("[TB] FAIL cont_results2: got %h expected %h", {r1, r2, r3, r4, terr}, e);
    end
  endtask

  task automatic test_init_ignored();
    bit ok;
    int aleSeen = 0;
    int doneLow = 0;
    expT e;
    dataTab = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
    sbQ.push_back('{8'h5A, 8'h6B, 8'h7C, 8'h8D, 1'b0});
    startScan();
    repeat (150) @(negedge clk);
    init = 1'b1;
    @(negedge clk) init = 1'b0;
    waitDone(3000, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL pulse_done: got 0 expected 1"); end
    e = sbQ.pop_front();
    checks++;
    if ({r1, r2, r3, r4, terr} !== e) begin
      errors++;
      $display("[TB] FAIL pulse_results: got %h expected %h", {r1, r2, r3, r4, terr}, e);
    end
    repeat (60) begin
      @(negedge clk);
      if (ale) aleSeen++;
      if (!done) doneLow++;
    end
    checks++;
    if (aleSeen != 0 || doneLow != 0) begin
      errors++;
      $display("[TB] FAIL single_scan_only: got ale %0d donelow %0d expected 0 0", aleSeen, doneLow);
    end
  endtask

  task automatic test_reset_mid_read();
    bit ok = 1'b0;
    int activity = 0;
    dataTab = '{8'h01, 8'h02, 8'h03, 8'h04};
    startScan();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (oe === 1'b1) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL reach_read: got 0 expected 1"); end
    #2 rstN = 1'b0;
    #1;
    checks++;
    if ({add, ale, start, oe, r1, r2, r3, r4, done, terr} !== 40'd0) begin
      errors++;
      $display("[TB] FAIL midread_reset: got %h expected 0",
               {add, ale, start, oe, r1, r2, r3, r4, done, terr});
    end
    @(negedge clk) rstN = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (ale || oe || done) activity++;
    end
    checks++;
    if (activity != 0) begin errors++; $display("[TB] FAIL idle_after_reset: got %0d expected 0", activity); end
  endtask

  initial begin
    dataTab = '{8'h00, 8'h00, 8'h00, 8'h00};
    test_reset();
    test_scan_timing();
    test_timeout();
    test_continuous();
    test_init_ignored();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
